// File: rtl/dm_arb_pkg.sv
// Shared widths and FSM state encoding for the data-memory arbiter.
package dm_arb_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/dm_arb.sv
// Two-port (CPU/DMA) arbiter in front of a single-port data memory, with
// round-robin fairness, bounded locked bursts and registered read return.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDR_W+1:2]   addr0,
    input  logic [ADDR_W+1:2]   addr1,
    input  logic [DATA_W-1:0]   wdata0,
    input  logic [DATA_W-1:0]   wdata1,
    input  logic                lock0,
    input  logic                lock1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W+1:2]   dm_addr,
    output logic [DATA_W-1:0]   dm_din,
    output logic                dm_we,
    input  logic [DATA_W-1:0]   dm_dout
);

    state_t             state;
    state_t             state_nxt;
    logic               rr_ptr;
    logic               rr_nxt;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W:0]     cnt_inc;
    logic               g0;
    logic               g1;
    logic               sel_lock;

    assign cnt_inc = (CNT_W+1)'(burst_cnt) + (CNT_W+1)'(1);

    // Grant decision, next-state and memory-side mux; grants are forced low in reset.
    always_comb begin
        g0        = 1'b0;
        g1        = 1'b0;
        sel_lock  = 1'b0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        cnt_nxt   = burst_cnt;

        case (state)
            ST_IDLE: begin
                g0 = req0 & (~req1 | ~rr_ptr);
                g1 = req1 & (~req0 |  rr_ptr);
            end
            ST_LOCK0: g0 = req0;
            ST_LOCK1: g1 = req1;
            default: ;
        endcase

        if (!rst_n) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end

        if (g0 | g1) begin
            sel_lock = g1 ? lock1 : lock0;
            if (sel_lock && (cnt_inc < (CNT_W+1)'(MAX_BURST))) begin
                state_nxt = g1 ? ST_LOCK1 : ST_LOCK0;
                cnt_nxt   = cnt_inc[CNT_W-1:0];
            end else begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                rr_nxt    = g0;
            end
        end else if (state != ST_IDLE) begin
            // Lock owner dropped its request: hand priority to the other port.
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            rr_nxt    = (state == ST_LOCK0);
        end
    end

    assign gnt0    = g0;
    assign gnt1    = g1;
    assign dm_addr = g0 ? addr0  : (g1 ? addr1  : '0);
    assign dm_din  = g0 ? wdata0 : (g1 ? wdata1 : '0);
    assign dm_we   = (g0 & we0) | (g1 & we1);

    // Arbitration state and one-cycle-latency read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
            rvalid0   <= g0 & ~we0;
            rvalid1   <= g1 & ~we1;
            if ((g0 & ~we0) | (g1 & ~we1)) begin
                rdata <= dm_dout;
            end
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb: directed scenarios plus randomized traffic
// against an ownership/priority reference model and a shadow memory.
module tb_dm_arb;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [11:2] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, dm_we;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [11:2] dm_addr;

    always #5 clk = ~clk;

    dm_arb #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_dout(dm_dout)
    );

    function automatic logic [31:0] init_word(input logic [9:0] a);
        return (a == 10'd1) ? 32'h20 : (32'hA500_0000 ^ ({22'h0, a} * 32'h9E37));
    endfunction

    // Data memory owned by the parent: combinational read, write at the edge.
    logic [31:0] mem     [1024];
    bit          written [1024];
    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr]     <= dm_din;
            written[dm_addr] <= 1'b1;
        end
    end
    assign dm_dout = written[dm_addr] ? mem[dm_addr] : init_word(dm_addr);

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          lock_owner;
    int          run_len;
    int          prio;
    logic [31:0] ref_mem [1024];
    logic        e_g0, e_g1, e_we, e_rv0, e_rv1;
    logic [9:0]  e_addr;
    logic [31:0] e_din, e_rdata;
    logic        s_g0, s_g1, s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_din;

    task automatic model_reset();
        lock_owner = -1;
        run_len    = 0;
        prio       = 0;
        e_rv0      = 1'b0;
        e_rv1      = 1'b0;
        e_rdata    = 32'h0;
    endtask

    // One clock: predict and snapshot combinational outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        int   p;
        logic lk;
        @(negedge clk);
        if (lock_owner == 0) begin
            e_g0 = req0; e_g1 = 1'b0;
        end else if (lock_owner == 1) begin
            e_g0 = 1'b0; e_g1 = req1;
        end else if (req0 && req1) begin
            e_g0 = (prio == 0); e_g1 = (prio == 1);
        end else begin
            e_g0 = req0; e_g1 = req1;
        end
        e_we   = e_g0 ? we0    : (e_g1 ? we1    : 1'b0);
        e_addr = e_g0 ? addr0  : (e_g1 ? addr1  : 10'h0);
        e_din  = e_g0 ? wdata0 : (e_g1 ? wdata1 : 32'h0);
        s_g0 = gnt0; s_g1 = gnt1; s_we = dm_we; s_addr = dm_addr; s_din = dm_din;
        @(posedge clk);
        e_rv0 = e_g0 && !we0;
        e_rv1 = e_g1 && !we1;
        if (e_rv0 || e_rv1) e_rdata = ref_mem[e_addr];
        if (e_we) ref_mem[e_addr] = e_din;
        if (e_g0 || e_g1) begin
            p  = e_g1 ? 1 : 0;
            lk = p ? lock1 : lock0;
            run_len++;
            if (lk && run_len < MAX_BURST) begin
                lock_owner = p;
            end else begin
                lock_owner = -1; run_len = 0; prio = 1 - p;
            end
        end else if (lock_owner != -1) begin
            prio = 1 - lock_owner; lock_owner = -1; run_len = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        req0 = 1; req1 = 1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1, dm_we, rvalid0, rvalid1} !== 5'b0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b%b we=%b rv=%b%b rdata=%h, want all zero",
                     gnt0, gnt1, dm_we, rvalid0, rvalid1, rdata);
        end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_alternate();
        req0 = 1; req1 = 1; addr0 = 10'd3; addr1 = 10'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (s_g0 !== (i % 2 == 0) || s_g1 !== (i % 2 == 1)) begin
                n_err++;
                $display("FAIL alternate[%0d]: got gnt=%b%b want %b%b", i, s_g0, s_g1,
                         (i % 2 == 0), (i % 2 == 1));
            end
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; addr0 = 10'd1;
        tick();
        n_cmp++;
        if (s_g0 !== 1'b1 || s_g1 !== 1'b0 || s_addr !== 10'd1) begin
            n_err++;
            $display("FAIL single_read_gnt: got gnt=%b%b addr=%0d want 10 addr=1", s_g0, s_g1, s_addr);
        end
        n_cmp++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 32'h20) begin
            n_err++;
            $display("FAIL single_read_data: got rv=%b%b rdata=%h want 10 00000020", rvalid0, rvalid1, rdata);
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (rvalid0 !== 1'b0 || rdata !== 32'h20) begin
            n_err++;
            $display("FAIL rvalid_pulse_hold: got rv0=%b rdata=%h want 0 00000020", rvalid0, rdata);
        end
    endtask

    task automatic test_burst();
        logic [5:0] pat;
        pat = 6'b101111;
        req0 = 1; req1 = 1; lock1 = 1; addr0 = 10'd7; addr1 = 10'd8;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (s_g1 !== pat[i] || s_g0 !== !pat[i]) begin
                n_err++;
                $display("FAIL burst[%0d]: got gnt=%b%b want %b%b", i, s_g0, s_g1, !pat[i], pat[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        req0 = 1; we0 = 1; addr0 = 10'd2; wdata0 = 32'h20;
        tick();
        n_cmp++;
        if (s_g0 !== 1'b1 || s_we !== 1'b1 || s_addr !== 10'd2 || s_din !== 32'h20) begin
            n_err++;
            $display("FAIL write_cycle: got gnt0=%b we=%b addr=%0d din=%h want 1 1 2 00000020",
                     s_g0, s_we, s_addr, s_din);
        end
        n_cmp++;
        if (rvalid0 !== 1'b0) begin
            n_err++;
            $display("FAIL write_no_rvalid: got rv0=%b want 0", rvalid0);
        end
        we0 = 0; wdata0 = 32'hDEAD_BEEF;
        tick();
        n_cmp++;
        if (s_we !== 1'b0 || rvalid0 !== 1'b1 || rdata !== 32'h20) begin
            n_err++;
            $display("FAIL read_after_write: got we=%b rv0=%b rdata=%h want 0 1 00000020", s_we, rvalid0, rdata);
        end
        idle_inputs();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({s_g0, s_g1, s_we} !== 3'b0 || s_addr !== 10'd0 || {rvalid0, rvalid1} !== 2'b0) begin
                n_err++;
                $display("FAIL idle[%0d]: got gnt=%b%b we=%b addr=%0d rv=%b%b want all zero",
                         i, s_g0, s_g1, s_we, s_addr, rvalid0, rvalid1);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        req0 = 1; we0 = 0; addr0 = 10'd5;
        @(negedge clk);
        n_cmp++;
        if (gnt0 !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_gnt: got gnt0=%b want 1", gnt0);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if (gnt0 !== 1'b0 || dm_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gnt_async: got gnt0=%b we=%b want 0 0", gnt0, dm_we);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rvalid0 !== 1'b0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_kills_read: got rv0=%b rdata=%h want 0 00000000", rvalid0, rdata);
        end
        idle_inputs();
        rst_n = 1;
        model_reset();
        req0 = 1; req1 = 1; addr0 = 10'd6; addr1 = 10'd9;
        tick();
        n_cmp++;
        if (s_g0 !== 1'b1 || s_g1 !== 1'b0 || rvalid0 !== 1'b1 || rdata !== ref_mem[6]) begin
            n_err++;
            $display("FAIL post_reset_arb: got gnt=%b%b rv0=%b rdata=%h want 10 1 %h",
                     s_g0, s_g1, rvalid0, rdata, ref_mem[6]);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req0   = ($urandom_range(3) != 0);
            req1   = ($urandom_range(3) != 0);
            we0    = ($urandom_range(2) == 0);
            we1    = ($urandom_range(2) == 0);
            lock0  = $urandom_range(1) == 1;
            lock1  = $urandom_range(1) == 1;
            addr0  = 10'($urandom_range(7));
            addr1  = 10'($urandom_range(7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            tick();
            n_cmp++;
            if (s_g0 !== e_g0 || s_g1 !== e_g1) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got %b%b want %b%b", i, s_g0, s_g1, e_g0, e_g1);
            end
            n_cmp++;
            if (s_we !== e_we || s_addr !== e_addr || s_din !== e_din) begin
                n_err++;
                $display("FAIL rand_dm[%0d]: got we=%b addr=%0d din=%h want we=%b addr=%0d din=%h",
                         i, s_we, s_addr, s_din, e_we, e_addr, e_din);
            end
            n_cmp++;
            if (rvalid0 !== e_rv0 || rvalid1 !== e_rv1 || rdata !== e_rdata) begin
                n_err++;
                $display("FAIL rand_rd[%0d]: got rv=%b%b rdata=%h want rv=%b%b rdata=%h",
                         i, rvalid0, rvalid1, rdata, e_rv0, e_rv1, e_rdata);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(10'(a));
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alternate();
        test_single_read();
        test_burst();
        test_write_read();
        test_idle();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive locked accesses by one port (range 1..15).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0/req1  input  1  port 0 (CPU) / port 1 (DMA) access request.
REQ-005 we0/we1  input  1  per-port write enable (1 = write, 0 = read).
REQ-006 addr0/addr1  input  [11:2]  per-port word address.
REQ-007 wdata0/wdata1  input  32  per-port write data.
REQ-008 lock0/lock1  input  1  request to keep ownership after this access.
REQ-009 gnt0/gnt1  output  1  access on that port is performed at the next rising clk edge.
REQ-010 rvalid0/rvalid1  output  1  one-cycle pulse: read data for that port is on rdata.
REQ-011 rdata  output  32  registered read data, shared by both ports.
REQ-012 dm_addr  output  [11:2]  address to the 4 KB data memory.
REQ-013 dm_din  output  32  write data to the data memory.
REQ-014 dm_we  output  1  write strobe to the data memory.
REQ-015 dm_dout  input  32  combinational read data from the data memory.

Function
REQ-016 At most one of gnt0/gnt1 SHALL be high in any cycle.
REQ-017 gnt SHALL be combinational from req and registered state; gnt_i high SHALL require req_i high.
REQ-018 States: IDLE, LOCK0, LOCK1; registers: state, rr_ptr (1 bit), burst_cnt (4 bits).
REQ-019 IDLE, one requester: grant it; both: grant port rr_ptr.
REQ-020 LOCKi: only port i SHALL be grantable; req_i low in LOCKi SHALL give no grant and return to IDLE, rr_ptr = other port.
REQ-021 Granted access with lock_i=1 and burst_cnt+1 < MAX_BURST: next state LOCKi, burst_cnt incremented.
REQ-022 Granted access with lock_i=0, or burst_cnt+1 = MAX_BURST: next state IDLE, burst_cnt = 0, rr_ptr = other port.
REQ-023 Granted cycle: dm_addr = addr_i, dm_din = wdata_i, dm_we = we_i; with no grant, dm_addr, dm_din and dm_we SHALL be 0.
REQ-024 Granted write SHALL commit at that edge; rvalid SHALL stay low for writes.
REQ-025 Granted read: rdata SHALL capture dm_dout at that edge; rvalid_i SHALL be high in the following cycle only (latency 1).
REQ-026 rdata SHALL hold its last value when no read completes.
REQ-027 Back-to-back reads SHALL give rvalid every cycle, with no bubble.
REQ-028 Write then read to the same address on consecutive grants SHALL return the new data.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, rr_ptr 0, burst_cnt 0, rvalid0/1 0, rdata 0, gnt0/1 0, dm_we 0.
REQ-030 A read granted in the cycle before reset asserts SHALL produce no rvalid; memory contents are not touched by reset.
REQ-031 The first edge after rst_n deasserts SHALL be arbitrated normally from IDLE.

Structure
REQ-032 Package dm_arb_pkg SHALL hold the state enum, address width (10), data width (32) and burst-counter width (4).
REQ-033 The block SHALL be a single flat module with no sub-module; the data memory is instantiated by the parent.

Verification
REQ-034 Reset, then req0 alone, read addr 1, memory word 1 = 0x20 -> gnt0 high same cycle; rvalid0 = 1 and rdata = 0x20 next cycle.
REQ-035 req0 and req1 both held, lock=0 -> grants alternate: 0, 1, 0, 1.
REQ-036 Port 1 holds lock1=1 and req1 for 6 cycles with req0 high, MAX_BURST=4 -> gnt1 for 4 cycles, then gnt0, then gnt1.
REQ-037 Port 0 write 0x20 to addr 2, then read addr 2 -> rdata = 0x20 with rvalid0; dm_we high only in the write cycle.
REQ-038 Read granted, then rst_n pulsed low before the next edge -> rvalid0 stays 0, rdata = 0, state IDLE.
REQ-039 No requests for 5 cycles -> gnt0/gnt1 = 0, dm_we = 0, dm_addr = 0, rvalid0/rvalid1 = 0.
